// File: rtl/alu_pipe.sv
// Handshaked ALU with registered result/flags, iterative shift-add MUL and a
// tri-state result bus. One op per input transfer, one result per output transfer.
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [3:0]       OPCODE,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  input  logic             OE,
  output logic [WIDTH-1:0] ALU_OUT,
  output logic             CF,
  output logic             OF,
  output logic             SF,
  output logic             ZF,
  output logic             ILL
);

  // One bit wider than the index so an amount of exactly WIDTH is expressible.
  localparam int SH_W  = $clog2(WIDTH) + 1;
  localparam int CNT_W = $clog2(WIDTH);
  localparam int MSB   = WIDTH - 1;

  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_XOR = 4'b0110;
  localparam logic [3:0] OP_NOT = 4'b0111;
  localparam logic [3:0] OP_SHL = 4'b1000;
  localparam logic [3:0] OP_SHR = 4'b1001;
  localparam logic [3:0] OP_ASR = 4'b1010;
  localparam logic [3:0] OP_MUL = 4'b1100;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] r;
    logic             cf;
    logic             of;
    logic             sf;
    logic             zf;
    logic             ill;
  } res_t;

  state_t             state_q, state_d;
  res_t               res_q, res_d, op_res;
  logic               op_is_mul;
  logic [2*WIDTH-1:0] mcand_q, mcand_d, acc_q, acc_d, acc_step;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               in_fire, out_fire;
  logic [SH_W-1:0]    sh_amt;
  logic [WIDTH:0]     sum, diff, shl_ext, shr_ext, asr_ext;

  function automatic res_t legal_res(input logic [WIDTH-1:0] r, input logic cf,
                                     input logic of);
    res_t x;
    x.r   = r;
    x.cf  = cf;
    x.of  = of;
    x.sf  = r[MSB];
    x.zf  = (r == '0);
    x.ill = 1'b0;
    return x;
  endfunction

  // The extra bit on each shift operand catches the last bit shifted out.
  assign sh_amt   = B[SH_W-1:0];
  assign sum      = {1'b0, A} + {1'b0, B};
  assign diff     = {1'b0, A} - {1'b0, B};
  assign shl_ext  = {1'b0, A} << sh_amt;
  assign shr_ext  = {A, 1'b0} >> sh_amt;
  assign asr_ext  = $signed({A, 1'b0}) >>> sh_amt;
  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

  assign IN_READY  = (state_q == IDLE) || ((state_q == DONE) && OUT_READY);
  assign OUT_VALID = (state_q == DONE);
  assign in_fire   = IN_VALID && IN_READY;
  assign out_fire  = OUT_VALID && OUT_READY;

  assign ALU_OUT = OE ? res_q.r : 'z;
  assign CF      = res_q.cf;
  assign OF      = res_q.of;
  assign SF      = res_q.sf;
  assign ZF      = res_q.zf;
  assign ILL     = res_q.ill;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    op_res     = '0;
    op_res.zf  = 1'b1;
    op_res.ill = 1'b1;
    op_is_mul  = 1'b0;
    case (OPCODE)
      OP_ADD: op_res = legal_res(sum[MSB:0], sum[WIDTH],
                                 (A[MSB] == B[MSB]) && (sum[MSB] != A[MSB]));
      OP_SUB: op_res = legal_res(diff[MSB:0], diff[WIDTH],
                                 (A[MSB] != B[MSB]) && (diff[MSB] != A[MSB]));
      OP_AND: op_res = legal_res(A & B, 1'b0, 1'b0);
      OP_OR:  op_res = legal_res(A | B, 1'b0, 1'b0);
      OP_XOR: op_res = legal_res(A ^ B, 1'b0, 1'b0);
      OP_NOT: op_res = legal_res(~A, 1'b0, 1'b0);
      OP_SHL: op_res = legal_res(shl_ext[MSB:0], shl_ext[WIDTH], 1'b0);
      OP_SHR: op_res = legal_res(shr_ext[WIDTH:1], shr_ext[0], 1'b0);
      OP_ASR: op_res = legal_res(asr_ext[WIDTH:1], asr_ext[0], 1'b0);
      OP_MUL: op_is_mul = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;

    case (state_q)
      BUSY: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
          cnt_d   = '0;
          res_d   = legal_res(acc_step[MSB:0], |acc_step[2*WIDTH-1:WIDTH],
                              |acc_step[2*WIDTH-1:WIDTH]);
        end
      end
      DONE: if (out_fire) state_d = IDLE;
      default: ;
    endcase

    // A new transfer overrides the drain to IDLE, giving back-to-back issue.
    if (in_fire) begin
      if (op_is_mul) begin
        state_d  = BUSY;
        mcand_d  = {{WIDTH{1'b0}}, A};
        mplier_d = B;
        acc_d    = '0;
        cnt_d    = '0;
      end else begin
        state_d = DONE;
        res_d   = op_res;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      res_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      res_q    <= res_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=8): directed plan cases plus random
// ops checked against an arithmetic reference model.
module tb_alu_pipe;

  localparam int W = 8;

  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_XOR = 4'b0110;
  localparam logic [3:0] OP_NOT = 4'b0111;
  localparam logic [3:0] OP_SHL = 4'b1000;
  localparam logic [3:0] OP_SHR = 4'b1001;
  localparam logic [3:0] OP_ASR = 4'b1010;
  localparam logic [3:0] OP_MUL = 4'b1100;

  typedef struct packed {
    logic [W-1:0] r;
    logic         cf;
    logic         of;
    logic         sf;
    logic         zf;
    logic         ill;
  } exp_t;

  logic         CLK = 1'b0;
  logic         RST, IN_VALID, IN_READY, OUT_VALID, OUT_READY, OE;
  logic         CF, OF, SF, ZF, ILL;
  logic [3:0]   OPCODE;
  logic [W-1:0] A, B;
  wire  [W-1:0] ALU_OUT;
  logic [W-1:0] z_val;

  int checks   = 0;
  int failures = 0;

  alu_pipe #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .OPCODE(OPCODE), .A(A), .B(B), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OE(OE), .ALU_OUT(ALU_OUT), .CF(CF), .OF(OF), .SF(SF), .ZF(ZF), .ILL(ILL)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Behavioural reference: integer arithmetic and bit-at-a-time shifting.
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t         e;
    int unsigned  ua, ub, full;
    int           sa, sb, s;
    logic [W-1:0] v;
    logic         c;
    e  = '0;
    ua = a;
    ub = b;
    sa = int'($signed(a));
    sb = int'($signed(b));
    v  = a;
    c  = 1'b0;
    case (op)
      OP_ADD: begin
        full = ua + ub;       e.r = full[W-1:0]; e.cf = (full >= 2**W);
        s = sa + sb;          e.of = (s > 2**(W-1) - 1) || (s < -(2**(W-1)));
      end
      OP_SUB: begin
        full = ua - ub;       e.r = full[W-1:0]; e.cf = (ua < ub);
        s = sa - sb;          e.of = (s > 2**(W-1) - 1) || (s < -(2**(W-1)));
      end
      OP_AND: e.r = a & b;
      OP_OR:  e.r = a | b;
      OP_XOR: e.r = a ^ b;
      OP_NOT: e.r = ~a;
      OP_SHL: begin
        for (int i = 0; i < int'(ub); i++) begin c = v[W-1]; v = v << 1; end
        e.r = v; e.cf = c;
      end
      OP_SHR: begin
        for (int i = 0; i < int'(ub); i++) begin c = v[0]; v = v >> 1; end
        e.r = v; e.cf = c;
      end
      OP_ASR: begin
        for (int i = 0; i < int'(ub); i++) begin c = v[0]; v = {v[W-1], v[W-1:1]}; end
        e.r = v; e.cf = c;
      end
      OP_MUL: begin
        full = ua * ub;       e.r = full[W-1:0];
        e.cf = (full >= 2**W); e.of = e.cf;
      end
      default: e.ill = 1'b1;
    endcase
    if (e.ill) e.zf = 1'b1;
    else begin
      e.sf = e.r[W-1];
      e.zf = (e.r == '0);
    end
    return e;
  endfunction

  task automatic check_out(input string tag, input exp_t e);
    check({tag, " valid"}, OUT_VALID, 1'b1);
    check({tag, " r"},  ALU_OUT, e.r);
    check({tag, " cf"}, CF, e.cf);
    check({tag, " of"}, OF, e.of);
    check({tag, " sf"}, SF, e.sf);
    check({tag, " zf"}, ZF, e.zf);
    check({tag, " ill"}, ILL, e.ill);
  endtask

  // Issue one op from IDLE, measure latency, optionally stall, then drain.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int stall);
    exp_t e;
    int   lat;
    e = model(op, a, b);
    check({tag, " ready"}, IN_READY, 1'b1);
    IN_VALID = 1'b1; OPCODE = op; A = a; B = b; OUT_READY = 1'b0;
    step();
    IN_VALID = 1'b0; OPCODE = 4'($urandom); A = W'($urandom); B = W'($urandom);
    lat = 0;
    while (!OUT_VALID && lat < 3 * W) begin
      check({tag, " busy ready"}, IN_READY, 1'b0);
      step();
      lat++;
    end
    check({tag, " latency"}, lat, (op == OP_MUL) ? W : 0);
    check_out(tag, e);
    for (int i = 0; i < stall; i++) begin
      step();
      check_out({tag, " stall"}, e);
    end
    OUT_READY = 1'b1;
    step();
    OUT_READY = 1'b0;
    check({tag, " drained"}, OUT_VALID, 1'b0);
  endtask

  initial begin
    exp_t e;
    logic [3:0] rop;
    logic [W-1:0] ra, rb;
    z_val = 'z;
    RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b0; OE = 1'b1;
    OPCODE = '0; A = '0; B = '0;
    #1;
    check("rst valid", OUT_VALID, 1'b0);
    check("rst flags", {CF, OF, SF, ZF, ILL}, 5'b0);
    check("rst alu_out", ALU_OUT, 8'h00);
    step(); step();
    RST = 1'b0;
    step();
    check("post-rst ready", IN_READY, 1'b1);

    // Reset mid-MUL: aborted, no result ever appears.
    IN_VALID = 1'b1; OPCODE = OP_MUL; A = 8'h0F; B = 8'h11;
    step();
    IN_VALID = 1'b0;
    step(); step(); step();
    RST = 1'b1;
    #1;
    check("midmul rst valid", OUT_VALID, 1'b0);
    check("midmul rst flags", {CF, OF, SF, ZF, ILL}, 5'b0);
    check("midmul rst alu_out", ALU_OUT, 8'h00);
    step();
    RST = 1'b0;
    step();
    check("midmul ready", IN_READY, 1'b1);
    for (int i = 0; i < 2 * W; i++) begin
      step();
      check("midmul no stale", OUT_VALID, 1'b0);
    end

    // ADD back-to-back with OUT_READY held high.
    OUT_READY = 1'b1;
    IN_VALID = 1'b1; OPCODE = OP_ADD; A = 8'h7F; B = 8'h01;
    step();
    check("add1 r", ALU_OUT, 8'h80);
    check("add1 flags cf/of/sf/zf", {CF, OF, SF, ZF}, 4'b0110);
    check("add1 ready", IN_READY, 1'b1);
    A = 8'hFF; B = 8'h01;
    step();
    IN_VALID = 1'b0;
    check("add2 valid", OUT_VALID, 1'b1);
    check("add2 r", ALU_OUT, 8'h00);
    check("add2 flags cf/of/sf/zf", {CF, OF, SF, ZF}, 4'b1001);
    step();
    OUT_READY = 1'b0;
    check("add2 drained", OUT_VALID, 1'b0);

    run_op("sub 05-06", OP_SUB, 8'h05, 8'h06, 0);
    run_op("sub 80-01", OP_SUB, 8'h80, 8'h01, 0);
    run_op("mul 0Fx11", OP_MUL, 8'h0F, 8'h11, 0);
    run_op("mul 10x10", OP_MUL, 8'h10, 8'h10, 1);
    run_op("shl 81<<1", OP_SHL, 8'h81, 8'h01, 0);
    run_op("asr 80>>>3", OP_ASR, 8'h80, 8'h03, 0);
    run_op("shr 80>>8", OP_SHR, 8'h80, 8'h08, 0);
    run_op("illegal 1111", 4'b1111, 8'h12, 8'h34, 0);

    // Backpressure: AND held 5 cycles while XOR waits; then both transfer.
    IN_VALID = 1'b1; OPCODE = OP_AND; A = 8'hF0; B = 8'h3C;
    step();
    OPCODE = OP_XOR; A = 8'hAA; B = 8'hAA;
    for (int i = 0; i < 5; i++) begin
      check("bp r", ALU_OUT, 8'h30);
      check("bp flags cf/of/sf/zf/ill", {CF, OF, SF, ZF, ILL}, 5'b0);
      check("bp valid", OUT_VALID, 1'b1);
      check("bp ready", IN_READY, 1'b0);
      step();
    end
    OUT_READY = 1'b1;
    #1;
    check("bp ready raised", IN_READY, 1'b1);
    step();
    IN_VALID = 1'b0;
    check("xor valid", OUT_VALID, 1'b1);
    check("xor r", ALU_OUT, 8'h00);
    check("xor zf", ZF, 1'b1);
    step();
    OUT_READY = 1'b0;
    check("xor drained", OUT_VALID, 1'b0);

    // OE: bus floats, flags unaffected.
    run_op("not 3C", OP_NOT, 8'h3C, 8'h00, 0);
    IN_VALID = 1'b1; OPCODE = OP_SUB; A = 8'h05; B = 8'h06;
    step();
    IN_VALID = 1'b0;
    OE = 1'b0;
    #1;
    check("oe0 alu_out", ALU_OUT, z_val);
    check("oe0 flags cf/of/sf/zf/ill", {CF, OF, SF, ZF, ILL}, 5'b10100);
    check("oe0 valid", OUT_VALID, 1'b1);
    OE = 1'b1;
    #1;
    check("oe1 alu_out", ALU_OUT, 8'hFF);
    OUT_READY = 1'b1;
    step();
    OUT_READY = 1'b0;

    // Random ops against the reference model.
    for (int n = 0; n < 60; n++) begin
      rop = 4'($urandom);
      ra  = W'($urandom);
      rb  = W'($urandom);
      if (rop inside {OP_SHL, OP_SHR, OP_ASR}) rb = W'($urandom_range(0, 15));
      run_op($sformatf("rand%0d op%0h", n, rop), rop, ra, rb, $urandom_range(0, 2));
    end

    // Random back-to-back stream with OUT_READY high: one result per cycle.
    OUT_READY = 1'b1;
    for (int n = 0; n < 20; n++) begin
      rop = ($urandom_range(0, 1) == 0) ? OP_ADD : OP_XOR;
      ra  = W'($urandom);
      rb  = W'($urandom);
      e   = model(rop, ra, rb);
      IN_VALID = 1'b1; OPCODE = rop; A = ra; B = rb;
      step();
      check_out($sformatf("b2b%0d", n), e);
      check("b2b ready", IN_READY, 1'b1);
    end
    IN_VALID = 1'b0;
    step();
    check("b2b drained", OUT_VALID, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
